// File: rtl/csoc_uart_pkg.sv
// csoc_uart_pkg: shared UART states, data width and tick-divider helper
package csoc_uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  function automatic int tick_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction
endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: synchronous FIFO, wrap-bit pointers, pop-before-push when full
module uart_rx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_pop, do_push;
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver into a byte FIFO (8E1 plus parity_err port when UART_RX_PARITY_EN is defined)
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] data_o,
  output logic       empty,
  output logic       full,
  output logic       overrun,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  input  logic       err_clr
);
  import csoc_uart_pkg::*;
  localparam int DIV = tick_div(CLK_HZ, BAUD, OVS);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVS);
  localparam logic [CW-1:0] T_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  logic [1:0] sync;
  logic rx_s, tick, mid, push;
  logic [CW-1:0] t_cnt;
  logic [SW-1:0] s_cnt;
  logic [2:0] b_cnt;
  logic [DATA_W-1:0] shreg;
  state_t state, state_n;
  assign rx_s = sync[1];
  always_comb begin
    tick = t_cnt == T_LAST;
    mid = tick && (s_cnt == ((state == START) ? S_HALF : {SW{1'b1}}));
    state_n = state;
    case (state)
      IDLE:   if (!rx_s) state_n = START;
      START:  if (mid) state_n = rx_s ? IDLE : DATA;
      DATA:   if (mid && b_cnt == 3'd7) state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) state_n = STOP;
`endif
      STOP:   if (mid) state_n = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      t_cnt <= '0;
      state <= IDLE;
      s_cnt <= '0;
      b_cnt <= '0;
      shreg <= '0;
      push <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], rx};
      t_cnt <= tick ? '0 : t_cnt + 1'b1;
      state <= state_n;
      s_cnt <= (state == IDLE || (state == START && mid)) ? '0 : s_cnt + SW'(tick);
      b_cnt <= (state == START) ? '0 : b_cnt + 3'(state == DATA && mid);
      if (state == DATA && mid) shreg <= {rx_s, shreg[DATA_W-1:1]};
      push <= state == STOP && mid && rx_s;
      frame_err <= (state == STOP && mid && !rx_s) || (frame_err && !err_clr);
      overrun <= (push && full && !rd_en) || (overrun && !err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err <= (state == PARITY && mid && (rx_s != ^shreg)) || (parity_err && !err_clr);
`endif
    end
  end
  uart_rx_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(rd_en),
    .din(shreg),
    .dout(data_o),
    .full(full),
    .empty(empty)
  );
endmodule
